imem_loader: RTL and testbench

// Boot-time program loader; sits directly upstream of the instruction memory read by the datapath.

---
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 172 +++++++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The master side is the loader: it consumes the byte stream and drives
// the memory write port. The slave side is the surrounding system.
interface imem_loader_if #(
  parameter int AddressWidth = 10
);
  logic                    byte_valid;
  logic [7:0]              byte_data;
  logic                    byte_ready;
  logic                    imem_wr_en;
  logic [AddressWidth-1:0] imem_wr_addr;
  logic [31:0]             imem_wr_data;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_wr_en,
    output imem_wr_addr,
    output imem_wr_data
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_wr_en,
    input  imem_wr_addr,
    input  imem_wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader. Takes a little-endian 16-bit word count followed
// by the program bytes, packs them into 32-bit little-endian words and writes
// them to instruction memory from address 0, holding the core in reset until
// the last word has been written.
module imem_loader #(
  parameter int AddressWidth = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  imem_loader_if.master bus,
  output logic          core_rst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o
);
  localparam int          WordIdxWidth = AddressWidth - 1;
  localparam logic [15:0] Capacity     = 16'(2 ** (AddressWidth - 2));

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERROR
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [WordIdxWidth-1:0] word_idx_q, word_idx_d;
  logic [23:0]             word_q, word_d;
  logic                    last_q, last_d;
  logic                    ready_q, ready_d;
  logic                    wr_en_q, wr_en_d;
  logic [AddressWidth-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]             wr_data_q, wr_data_d;
  logic                    core_rst_q, core_rst_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    accept;
  logic                    session_d;
  logic [15:0]             len_full;

  assign accept   = bus.byte_valid && ready_q;
  assign len_full = {bus.byte_data, len_q[7:0]};

  // Next-state, datapath and registered-output decode.
  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    word_d     = word_q;
    last_d     = last_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        // A new session always starts from clean counters.
        if (start_i) begin
          state_d    = LEN_LO;
          len_d      = '0;
          byte_idx_d = '0;
          word_idx_d = '0;
          word_d     = '0;
          last_d     = 1'b0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = bus.byte_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = DONE;
          end else if (len_full > Capacity) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // After the last word, wait out its strobe cycle before releasing
        // the core so no write is still in flight.
        if (last_q) begin
          state_d = DONE;
        end else if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = bus.byte_data;
            2'd1: word_d[15:8]  = bus.byte_data;
            2'd2: word_d[23:16] = bus.byte_data;
            default: begin
              wr_en_d    = 1'b1;
              wr_data_d  = {bus.byte_data, word_q};
              wr_addr_d  = {word_idx_q[AddressWidth-3:0], 2'b00};
              word_idx_d = word_idx_q + WordIdxWidth'(1);
              if (16'(word_idx_q) + 16'd1 == len_q) begin
                last_d = 1'b1;
              end
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    session_d  = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
    ready_d    = session_d && !last_d;
    busy_d     = session_d;
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERROR);
    core_rst_d = (state_d != DONE);
  end

  // State, counters and output registers; reset drops any partial word.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      word_q     <= word_d;
      last_q     <= last_d;
      ready_q    <= ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.byte_ready   = ready_q;
  assign bus.imem_wr_en   = wr_en_q;
  assign bus.imem_wr_addr = wr_addr_q;
  assign bus.imem_wr_data = wr_data_q;
  assign core_rst_o       = core_rst_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A session-level model turns each byte
// stream into the list of (address, word) writes it must produce; a compare
// process matches every write strobe against that list, and directed checks
// pin status outputs and a few literal words.
module tb_imem_loader;
  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_i;
  logic start_i;
  logic core_rst_o, busy_o, done_o, error_o;

  imem_loader_if #(.AddressWidth(10)) bus ();

  imem_loader #(.AddressWidth(10)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .bus        (bus.master),
    .core_rst_o (core_rst_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o)
  );

  always #5 clk = ~clk;

  int  tests = 0;
  int  fails = 0;
  wr_t exp_q[$];
  wr_t wr_log[$];
  wr_t got_w, exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_status(input string name, input logic rdy, input logic bsy,
                              input logic dn, input logic err, input logic crst);
    check({name, ".ready"},    32'(bus.byte_ready), 32'(rdy));
    check({name, ".busy"},     32'(busy_o),         32'(bsy));
    check({name, ".done"},     32'(done_o),         32'(dn));
    check({name, ".error"},    32'(error_o),        32'(err));
    check({name, ".core_rst"}, 32'(core_rst_o),     32'(crst));
  endtask

  // Session model: length field, then as many complete words as were sent,
  // capped by the length; an over-capacity length produces nothing.
  task automatic model_session(input logic [7:0] s[$]);
    int  len, nwords, b;
    wr_t w;
    if (s.size() < 2) return;
    len = int'(s[0]) + 256 * int'(s[1]);
    if (len > 256) return;
    nwords = (s.size() - 2) / 4;
    if (nwords > len) nwords = len;
    for (int i = 0; i < nwords; i++) begin
      b      = 2 + 4 * i;
      w.addr = 10'(4 * i);
      w.data = {s[b+3], s[b+2], s[b+1], s[b]};
      exp_q.push_back(w);
    end
  endtask

  // Every write strobe must match the next model write, in order.
  always @(negedge clk) begin
    if (rst_i && bus.imem_wr_en) begin
      got_w.addr = bus.imem_wr_addr;
      got_w.data = bus.imem_wr_data;
      wr_log.push_back(got_w);
      check("wr_core_held", 32'(core_rst_o), 32'd1);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, required no write",
                 got_w.addr, got_w.data);
      end else begin
        exp_w = exp_q.pop_front();
        check("wr_addr", 32'(got_w.addr), 32'(exp_w.addr));
        check("wr_data", got_w.data, exp_w.data);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b, input bit gappy, input bit pulse);
    int waited = 0;
    if (gappy) begin
      while ($urandom_range(1, 0) == 0) begin
        bus.byte_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    start_i        = pulse;
    while (!bus.byte_ready && waited < 64) begin
      @(negedge clk);
      start_i = 1'b0;
      waited++;
    end
    if (!bus.byte_ready) begin
      tests++;
      fails++;
      $display("FAIL byte_accept_timeout: got ready 0 for %0d cycles, required 1", waited);
      bus.byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gappy, input int pulse_at);
    for (int i = 0; i < s.size(); i++) send_byte(s[i], gappy, i == pulse_at);
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", 32'(done_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog2[$];
    logic [7:0] s[$];
    int base;

    prog2 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

    rst_i          = 1'b0;
    start_i        = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset.wr_en", 32'(bus.imem_wr_en), 32'd0);
    rst_i = 1'b1;
    @(negedge clk);
    check_status("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 1: reset after 6 program bytes; only the first complete word is written.
    pulse_start();
    check_status("t1_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    s = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    model_session(s);
    send_stream(s, 1'b0, -1);
    rst_i = 1'b0;
    #1;
    check_status("t1_async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_rst.wr_en", 32'(bus.imem_wr_en), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check_status("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_partial_word", 32'(wr_log.size()), 32'd1);

    // 2: two-word program with valid held high.
    base = wr_log.size();
    pulse_start();
    model_session(prog2);
    send_stream(prog2, 1'b0, -1);
    check("t2_strobe", 32'(bus.imem_wr_en), 32'd1);
    check_status("t2_strobe", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_status("t2_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t2_wr_en_off", 32'(bus.imem_wr_en), 32'd0);
    check("t2_nwrites", 32'(wr_log.size() - base), 32'd2);
    check("t2_addr0", 32'(wr_log[base].addr), 32'h000);
    check("t2_data0", wr_log[base].data, 32'h00100513);
    check("t2_addr1", 32'(wr_log[base+1].addr), 32'h004);
    check("t2_data1", wr_log[base+1].data, 32'h00200593);

    // 3: same program, valid toggling randomly.
    base = wr_log.size();
    pulse_start();
    model_session(prog2);
    send_stream(prog2, 1'b1, -1);
    wait_done();
    check("t3_nwrites", 32'(wr_log.size() - base), 32'd2);
    check("t3_data1", wr_log[base+1].data, 32'h00200593);

    // 4: zero length, over-capacity length, then retry.
    base = wr_log.size();
    pulse_start();
    send_stream('{8'h00, 8'h00}, 1'b0, -1);
    check_status("t4_zero", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_start();
    send_stream('{8'h01, 8'h01}, 1'b0, -1);
    check_status("t4_err", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check_status("t4_err_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t4_no_writes", 32'(wr_log.size() - base), 32'd0);
    pulse_start();
    check_status("t4_retry", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    model_session(s);
    send_stream(s, 1'b0, -1);
    wait_done();
    check("t4_data", wr_log[wr_log.size()-1].data, 32'h44332211);

    // 5: full-capacity program of 256 words; extra bytes refused.
    base = wr_log.size();
    s = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < 4; k++) s.push_back(8'(i * 3 + k * 61 + 1));
    pulse_start();
    model_session(s);
    send_stream(s, 1'b0, -1);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    check("t5_ready_last", 32'(bus.byte_ready), 32'd0);
    @(negedge clk);
    check("t5_nwrites", 32'(wr_log.size() - base), 32'd256);
    check("t5_first_addr", 32'(wr_log[base].addr), 32'h000);
    check("t5_last_addr", 32'(wr_log[wr_log.size()-1].addr), 32'h3FC);
    for (int i = 0; i < 3; i++) begin
      check_status("t5_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    check("t5_no_extra", 32'(wr_log.size() - base), 32'd256);

    // 6: reload from DONE; start pulse during DATA is ignored.
    pulse_start();
    check_status("t6_reload", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_session(s);
    send_stream('{8'h01, 8'h00, 8'hEF, 8'hBE}, 1'b0, 3);
    check_status("t6_mid", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_stream('{8'hAD, 8'hDE}, 1'b0, -1);
    wait_done();
    check("t6_addr", 32'(wr_log[wr_log.size()-1].addr), 32'h000);
    check("t6_data", wr_log[wr_log.size()-1].data, 32'hDEADBEEF);
    check("t6_core_rel", 32'(core_rst_o), 32'd0);

    repeat (2) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
